axi_read_arbiter_2to1: RTL and testbench

//  Merges the AR/R channels of two AXI masters (M0, M1) onto one slave-side read port.

---
 rtl/axi_read_arbiter_2to1_if.sv | 38 +++
 rtl/axi_read_arbiter_2to1.sv | 142 ++++++++++++++
 tb/tb_axi_read_arbiter_2to1.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_read_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter_2to1_if
//  Description : AXI read-channel bundle (AR + R) with master/slave views.
//                One instance per master port and one for the slave port.
//  Revision    : 1.0  initial release
// ============================================================================
interface axi_read_arbiter_2to1_if #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
);
    logic [ID_BITS-1:0]   arid;
    logic [ADDR_BITS-1:0] araddr;
    logic [LEN_BITS-1:0]  arlen;
    logic                 arvalid;
    logic                 arready;
    logic [ID_BITS-1:0]   rid;
    logic [DATA_BITS-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    // Request issuer: drives AR payload/valid and R ready.
    modport master (
        output arid, araddr, arlen, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    // Request responder: drives AR ready and the R channel.
    modport slave (
        input  arid, araddr, arlen, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_read_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : axi_read_arbiter_2to1
//  Description : Round-robin merge of two AXI read masters onto one slave
//                read port. One burst outstanding; grant held until the
//                owner's RLAST handshake. Owner bit prefixes the slave ARID.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_read_arbiter_2to1 #(
    parameter int ID_BITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_read_arbiter_2to1_if.slave  m0,
    axi_read_arbiter_2to1_if.slave  m1,
    axi_read_arbiter_2to1_if.master s
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t state_q;
    logic   owner_q;   // master currently holding the grant
    logic   prio_q;    // master preferred on the next simultaneous request

    // Owner-selected request/response-side inputs.
    logic [ID_BITS-1:0]   w_own_arid;
    logic [ADDR_BITS-1:0] w_own_araddr;
    logic [LEN_BITS-1:0]  w_own_arlen;
    logic                 w_own_arvalid;
    logic                 w_own_rready;
    logic                 w_ar_hs;
    logic                 w_r_done;
    logic                 w_unused_rid_msb;

    assign w_own_arid    = owner_q ? m1.arid    : m0.arid;
    assign w_own_araddr  = owner_q ? m1.araddr  : m0.araddr;
    assign w_own_arlen   = owner_q ? m1.arlen   : m0.arlen;
    assign w_own_arvalid = owner_q ? m1.arvalid : m0.arvalid;
    assign w_own_rready  = owner_q ? m1.rready  : m0.rready;

    assign w_ar_hs  = (state_q == S_ADDR) && w_own_arvalid && s.arready;
    assign w_r_done = (state_q == S_DATA) && s.rvalid && w_own_rready && s.rlast;

    // Return routing relies on owner_q, so the slave's echoed owner bit is not used.
    assign w_unused_rid_msb = s.rid[ID_BITS];

    // Grant FSM: register the winner in IDLE, hold it until the RLAST handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (m0.arvalid && m1.arvalid) begin
                        owner_q <= prio_q;
                        state_q <= S_ADDR;
                    end else if (m0.arvalid) begin
                        owner_q <= 1'b0;
                        state_q <= S_ADDR;
                    end else if (m1.arvalid) begin
                        owner_q <= 1'b1;
                        state_q <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_ar_hs) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_r_done) begin
                        state_q <= S_IDLE;
                        prio_q  <= ~owner_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Per-state steering of AR towards the slave and R back to the owner.
    always_comb begin
        m0.arready = 1'b0;
        m1.arready = 1'b0;
        s.arid     = '0;
        s.araddr   = '0;
        s.arlen    = '0;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        m0.rid     = '0;
        m0.rdata   = '0;
        m0.rresp   = 2'b00;
        m0.rlast   = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rid     = '0;
        m1.rdata   = '0;
        m1.rresp   = 2'b00;
        m1.rlast   = 1'b0;
        m1.rvalid  = 1'b0;
        case (state_q)
            S_ADDR: begin
                s.arid    = {owner_q, w_own_arid};
                s.araddr  = w_own_araddr;
                s.arlen   = w_own_arlen;
                s.arvalid = w_own_arvalid;
                if (owner_q) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
            end
            S_DATA: begin
                s.rready = w_own_rready;
                if (owner_q) begin
                    m1.rid    = s.rid[ID_BITS-1:0];
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rlast  = s.rlast;
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rid    = s.rid[ID_BITS-1:0];
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rlast  = s.rlast;
                    m0.rvalid = s.rvalid;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter_2to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_read_arbiter_2to1
//  Description : Directed self-checking bench for axi_read_arbiter_2to1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_read_arbiter_2to1;

    logic clk;
    logic rst;
    int   nchecks;
    int   nerrors;

    axi_read_arbiter_2to1_if #(.ID_BITS(4)) m0_bus ();
    axi_read_arbiter_2to1_if #(.ID_BITS(4)) m1_bus ();
    axi_read_arbiter_2to1_if #(.ID_BITS(5)) s_bus ();

    axi_read_arbiter_2to1 #(
        .ID_BITS(4), .ADDR_BITS(32), .DATA_BITS(32), .LEN_BITS(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input logic v, input logic [3:0] id, input logic [31:0] a, input logic [3:0] l);
        m0_bus.arvalid = v; m0_bus.arid = id; m0_bus.araddr = a; m0_bus.arlen = l;
    endtask

    task automatic set_m1(input logic v, input logic [3:0] id, input logic [31:0] a, input logic [3:0] l);
        m1_bus.arvalid = v; m1_bus.arid = id; m1_bus.araddr = a; m1_bus.arlen = l;
    endtask

    task automatic s_beat(input logic v, input logic [4:0] id, input logic [31:0] d, input logic last);
        s_bus.rvalid = v; s_bus.rid = id; s_bus.rdata = d; s_bus.rlast = last; s_bus.rresp = 2'b00;
    endtask

    task automatic clear_inputs();
        set_m0(1'b0, 4'h0, 32'h0, 4'h0);
        set_m1(1'b0, 4'h0, 32'h0, 4'h0);
        m0_bus.rready = 1'b0;
        m1_bus.rready = 1'b0;
        s_bus.arready = 1'b0;
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        s_beat(1'b1, 5'h03, 32'hDEAD_BEEF, 1'b1);
        m0_bus.rready = 1'b1;
        tick();
        tick();
        nchecks++; if (s_bus.arvalid !== 1'b0) begin nerrors++; $display("FAIL rst_s_arvalid: got %0h want 0", s_bus.arvalid); end
        nchecks++; if (s_bus.rready !== 1'b0) begin nerrors++; $display("FAIL rst_s_rready: got %0h want 0", s_bus.rready); end
        nchecks++; if ({m0_bus.arready, m1_bus.arready} !== 2'b00) begin nerrors++; $display("FAIL rst_arready: got %0h want 0", {m0_bus.arready, m1_bus.arready}); end
        nchecks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b00) begin nerrors++; $display("FAIL rst_rvalid: got %0h want 0", {m0_bus.rvalid, m1_bus.rvalid}); end
        nchecks++; if (m0_bus.rdata !== 32'h0) begin nerrors++; $display("FAIL rst_m0_rdata: got %0h want 0", m0_bus.rdata); end
        nchecks++; if ({s_bus.arid, s_bus.araddr, s_bus.arlen} !== 41'h0) begin nerrors++; $display("FAIL rst_s_ar_payload: got %0h want 0", {s_bus.arid, s_bus.araddr, s_bus.arlen}); end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_m0();
        do_reset();
        set_m0(1'b1, 4'h3, 32'h0000_0100, 4'h3);
        s_bus.arready = 1'b1;
        tick();  // IDLE -> ADDR
        nchecks++; if (s_bus.arvalid !== 1'b1) begin nerrors++; $display("FAIL t1_s_arvalid: got %0h want 1", s_bus.arvalid); end
        nchecks++; if (s_bus.arid !== 5'h03) begin nerrors++; $display("FAIL t1_s_arid: got %0h want 03", s_bus.arid); end
        nchecks++; if (s_bus.araddr !== 32'h100) begin nerrors++; $display("FAIL t1_s_araddr: got %0h want 100", s_bus.araddr); end
        nchecks++; if (s_bus.arlen !== 4'h3) begin nerrors++; $display("FAIL t1_s_arlen: got %0h want 3", s_bus.arlen); end
        nchecks++; if ({m0_bus.arready, m1_bus.arready} !== 2'b10) begin nerrors++; $display("FAIL t1_arready: got %0h want 2", {m0_bus.arready, m1_bus.arready}); end
        tick();  // ADDR -> DATA
        set_m0(1'b0, 4'h0, 32'h0, 4'h0);
        m0_bus.rready = 1'b1;
        nchecks++; if (s_bus.arvalid !== 1'b0) begin nerrors++; $display("FAIL t1_data_s_arvalid: got %0h want 0", s_bus.arvalid); end
        for (int i = 0; i < 4; i++) begin
            s_beat(1'b1, 5'h03, 32'hD000_0000 + 32'(i), (i == 3));
            #1;
            nchecks++; if (m0_bus.rvalid !== 1'b1) begin nerrors++; $display("FAIL t1_m0_rvalid beat %0d: got %0h want 1", i, m0_bus.rvalid); end
            nchecks++; if (m0_bus.rdata !== 32'hD000_0000 + 32'(i)) begin nerrors++; $display("FAIL t1_m0_rdata beat %0d: got %0h want %0h", i, m0_bus.rdata, 32'hD000_0000 + 32'(i)); end
            nchecks++; if (m0_bus.rlast !== (i == 3)) begin nerrors++; $display("FAIL t1_m0_rlast beat %0d: got %0h want %0h", i, m0_bus.rlast, (i == 3)); end
            nchecks++; if (m0_bus.rid !== 4'h3) begin nerrors++; $display("FAIL t1_m0_rid beat %0d: got %0h want 3", i, m0_bus.rid); end
            nchecks++; if (s_bus.rready !== 1'b1) begin nerrors++; $display("FAIL t1_s_rready beat %0d: got %0h want 1", i, s_bus.rready); end
            nchecks++; if (m1_bus.rvalid !== 1'b0) begin nerrors++; $display("FAIL t1_m1_rvalid beat %0d: got %0h want 0", i, m1_bus.rvalid); end
            tick();
        end
        // Back in IDLE: a lingering s_rvalid must be ignored.
        nchecks++; if (s_bus.rready !== 1'b0) begin nerrors++; $display("FAIL t1_idle_s_rready: got %0h want 0", s_bus.rready); end
        nchecks++; if (m0_bus.rvalid !== 1'b0) begin nerrors++; $display("FAIL t1_idle_m0_rvalid: got %0h want 0", m0_bus.rvalid); end
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_m0(1'b1, 4'h1, 32'h0000_0200, 4'h0);
        set_m1(1'b1, 4'h2, 32'h0000_0300, 4'h1);
        s_bus.arready = 1'b1;
        m0_bus.rready = 1'b1;
        m1_bus.rready = 1'b1;
        tick();
        nchecks++; if (s_bus.arid !== 5'h01) begin nerrors++; $display("FAIL t2_first_arid: got %0h want 01", s_bus.arid); end
        nchecks++; if ({m0_bus.arready, m1_bus.arready} !== 2'b10) begin nerrors++; $display("FAIL t2_first_arready: got %0h want 2", {m0_bus.arready, m1_bus.arready}); end
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 4'h0);
        s_beat(1'b1, 5'h01, 32'h0000_AAAA, 1'b1);
        #1;
        nchecks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== 2'b10) begin nerrors++; $display("FAIL t2_m0_data_rvalid: got %0h want 2", {m0_bus.rvalid, m1_bus.rvalid}); end
        tick();  // RLAST handshake -> IDLE
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
        nchecks++; if (s_bus.arvalid !== 1'b0) begin nerrors++; $display("FAIL t2_gap_s_arvalid: got %0h want 0", s_bus.arvalid); end
        tick();  // IDLE grants M1
        nchecks++; if (s_bus.arid !== 5'h12) begin nerrors++; $display("FAIL t2_second_arid: got %0h want 12", s_bus.arid); end
        nchecks++; if (s_bus.araddr !== 32'h300) begin nerrors++; $display("FAIL t2_second_araddr: got %0h want 300", s_bus.araddr); end
        nchecks++; if ({m0_bus.arready, m1_bus.arready} !== 2'b01) begin nerrors++; $display("FAIL t2_second_arready: got %0h want 1", {m0_bus.arready, m1_bus.arready}); end
        tick();
        set_m1(1'b0, 4'h0, 32'h0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            s_beat(1'b1, 5'h12, 32'hB000_0000 + 32'(i), (i == 1));
            #1;
            nchecks++; if (m1_bus.rdata !== 32'hB000_0000 + 32'(i)) begin nerrors++; $display("FAIL t2_m1_rdata beat %0d: got %0h want %0h", i, m1_bus.rdata, 32'hB000_0000 + 32'(i)); end
            nchecks++; if (m1_bus.rid !== 4'h2) begin nerrors++; $display("FAIL t2_m1_rid beat %0d: got %0h want 2", i, m1_bus.rid); end
            nchecks++; if (m0_bus.rvalid !== 1'b0) begin nerrors++; $display("FAIL t2_m0_rvalid beat %0d: got %0h want 0", i, m0_bus.rvalid); end
            tick();
        end
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
    endtask

    task automatic test_round_robin();
        logic exp_owner;
        do_reset();
        set_m0(1'b1, 4'h4, 32'h0000_1000, 4'h0);
        set_m1(1'b1, 4'h5, 32'h0000_2000, 4'h0);
        s_bus.arready = 1'b1;
        m0_bus.rready = 1'b1;
        m1_bus.rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_owner = k[0];
            tick();  // IDLE -> ADDR
            nchecks++; if (s_bus.arid !== (exp_owner ? 5'h15 : 5'h04)) begin nerrors++; $display("FAIL t3_arid burst %0d: got %0h want %0h", k, s_bus.arid, (exp_owner ? 5'h15 : 5'h04)); end
            nchecks++; if ((exp_owner ? m0_bus.arready : m1_bus.arready) !== 1'b0) begin nerrors++; $display("FAIL t3_nonowner_arready burst %0d: got 1 want 0", k); end
            tick();  // ADDR -> DATA
            s_beat(1'b1, {exp_owner, 4'h0}, 32'hC000_0000 + 32'(k), 1'b1);
            #1;
            nchecks++; if ({m0_bus.arready, m1_bus.arready} !== 2'b00) begin nerrors++; $display("FAIL t3_data_arready burst %0d: got %0h want 0", k, {m0_bus.arready, m1_bus.arready}); end
            nchecks++; if ({m0_bus.rvalid, m1_bus.rvalid} !== (exp_owner ? 2'b01 : 2'b10)) begin nerrors++; $display("FAIL t3_rvalid burst %0d: got %0h want %0h", k, {m0_bus.rvalid, m1_bus.rvalid}, (exp_owner ? 2'b01 : 2'b10)); end
            tick();  // RLAST -> IDLE
            s_beat(1'b0, 5'h00, 32'h0, 1'b0);
        end
    endtask

    task automatic test_backpressure_r();
        do_reset();
        set_m0(1'b1, 4'h7, 32'h0000_4000, 4'h0);
        s_bus.arready = 1'b1;
        tick();
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 4'h0);
        m0_bus.rready = 1'b0;
        m1_bus.rready = 1'b1;
        s_beat(1'b1, 5'h07, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            nchecks++; if (s_bus.rready !== 1'b0) begin nerrors++; $display("FAIL t4_s_rready cyc %0d: got %0h want 0", i, s_bus.rready); end
            nchecks++; if (m0_bus.rvalid !== 1'b1) begin nerrors++; $display("FAIL t4_m0_rvalid cyc %0d: got %0h want 1", i, m0_bus.rvalid); end
            nchecks++; if (m1_bus.rvalid !== 1'b0) begin nerrors++; $display("FAIL t4_m1_rvalid cyc %0d: got %0h want 0", i, m1_bus.rvalid); end
            tick();
        end
        m0_bus.rready = 1'b1;
        #1;
        nchecks++; if (s_bus.rready !== 1'b1) begin nerrors++; $display("FAIL t4_release_s_rready: got %0h want 1", s_bus.rready); end
        tick();
        nchecks++; if (m0_bus.rvalid !== 1'b0) begin nerrors++; $display("FAIL t4_after_m0_rvalid: got %0h want 0", m0_bus.rvalid); end
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        // Complete one M0 burst so the preference moves to M1.
        set_m0(1'b1, 4'h1, 32'h0000_5000, 4'h0);
        s_bus.arready = 1'b1;
        m0_bus.rready = 1'b1;
        tick();
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 4'h0);
        s_beat(1'b1, 5'h01, 32'h0, 1'b1);
        tick();
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
        // Long M0 burst, reset while beat 2 is on the bus.
        set_m0(1'b1, 4'h1, 32'h0000_6000, 4'h7);
        tick();
        tick();
        set_m0(1'b0, 4'h0, 32'h0, 4'h0);
        s_beat(1'b1, 5'h01, 32'h0000_0001, 1'b0);
        tick();
        s_beat(1'b1, 5'h01, 32'h0000_0002, 1'b0);
        #1;
        nchecks++; if (m0_bus.rvalid !== 1'b1) begin nerrors++; $display("FAIL t5_pre_rvalid: got %0h want 1", m0_bus.rvalid); end
        rst = 1'b1;
        tick();
        nchecks++; if ({s_bus.arvalid, s_bus.rready} !== 2'b00) begin nerrors++; $display("FAIL t5_s_valid_ready: got %0h want 0", {s_bus.arvalid, s_bus.rready}); end
        nchecks++; if ({m0_bus.rvalid, m1_bus.rvalid, m0_bus.arready, m1_bus.arready} !== 4'h0) begin nerrors++; $display("FAIL t5_m_valid_ready: got %0h want 0", {m0_bus.rvalid, m1_bus.rvalid, m0_bus.arready, m1_bus.arready}); end
        rst = 1'b0;
        s_beat(1'b0, 5'h00, 32'h0, 1'b0);
        set_m0(1'b1, 4'h2, 32'h0000_7000, 4'h0);
        set_m1(1'b1, 4'h3, 32'h0000_8000, 4'h0);
        tick();
        nchecks++; if (s_bus.arid !== 5'h02) begin nerrors++; $display("FAIL t5_prio_after_rst: got %0h want 02", s_bus.arid); end
    endtask

    task automatic test_ar_stall();
        do_reset();
        set_m1(1'b1, 4'h6, 32'h0000_ABC0, 4'h2);
        s_bus.arready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            nchecks++; if ({s_bus.arvalid, s_bus.arid, s_bus.araddr, s_bus.arlen} !== {1'b1, 5'h16, 32'h0000_ABC0, 4'h2}) begin nerrors++; $display("FAIL t6_ar_stable cyc %0d: got %0h want %0h", i, {s_bus.arvalid, s_bus.arid, s_bus.araddr, s_bus.arlen}, {1'b1, 5'h16, 32'h0000_ABC0, 4'h2}); end
            nchecks++; if (m1_bus.arready !== 1'b0) begin nerrors++; $display("FAIL t6_m1_arready cyc %0d: got %0h want 0", i, m1_bus.arready); end
            tick();
        end
        s_bus.arready = 1'b1;
        #1;
        nchecks++; if (m1_bus.arready !== 1'b1) begin nerrors++; $display("FAIL t6_m1_arready_rise: got %0h want 1", m1_bus.arready); end
        tick();
        set_m1(1'b0, 4'h0, 32'h0, 4'h0);
        nchecks++; if (s_bus.arvalid !== 1'b0) begin nerrors++; $display("FAIL t6_data_s_arvalid: got %0h want 0", s_bus.arvalid); end
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_m0();
        test_simultaneous();
        test_round_robin();
        test_backpressure_r();
        test_reset_mid_burst();
        test_ar_stall();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
